// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_done);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_done);
endinterface

// File: rtl/fetch_stage.sv
// WISC instruction-fetch stage: owns the PC, talks to a variable-latency imem,
// and drives the IF/ID pipeline register.
//
// state  | meaning
// REQ    | request outstanding at req_addr
// HOLD   | instruction returned under stall, parked in skid buffer
// DROP   | redirected while a request was in flight; wait and discard it
// HALTED | HALT delivered, no further fetches until a redirect
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallCtrl,
  input  logic                 takeBranch_EXMEM,
  input  logic [15:0]          branchTarget_EXMEM,
  input  logic                 jumpFlush,
  input  logic [15:0]          jumpTarget,
  fetch_stage_if.master        imem,
  output logic [15:0]          instr_IFID,
  output logic [15:0]          PC_IFID,
  output logic [15:0]          PC2_IFID,
  output logic                 halt_IFID,
  output logic                 valid_IFID,
  output logic                 err
);

  typedef enum logic [1:0] {ST_REQ, ST_HOLD, ST_DROP, ST_HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_ifid_q, pc_ifid_d;
  logic [15:0] pc2_ifid_q, pc2_ifid_d;
  logic        halt_q, halt_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        redirect;
  logic [15:0] target;
  logic        in_flight;

  assign redirect  = takeBranch_EXMEM | jumpFlush;
  assign target    = takeBranch_EXMEM ? branchTarget_EXMEM : jumpTarget;
  assign in_flight = (state_q == ST_REQ) || (state_q == ST_DROP);

  // rst only masks the request during the reset cycle so memory sees no new fetch
  assign imem.imem_req  = in_flight & ~rst;
  assign imem.imem_addr = req_addr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_ifid_d    = pc_ifid_q;
    pc2_ifid_d   = pc2_ifid_q;
    halt_d       = halt_q;
    valid_d      = valid_q;
    err_d        = err_q;

    case (state_q)
      ST_REQ: begin
        if (imem.imem_done) begin
          if (stallCtrl) begin
            skid_instr_d = imem.imem_rdata;
            skid_pc_d    = req_addr_q;
            state_d      = ST_HOLD;
          end else begin
            instr_d    = imem.imem_rdata;
            pc_ifid_d  = req_addr_q;
            pc2_ifid_d = req_addr_q + 16'd2;
            halt_d     = (imem.imem_rdata[15:11] == 5'b00000);
            valid_d    = 1'b1;
            pc_d       = req_addr_q + 16'd2;
            req_addr_d = req_addr_q + 16'd2;
            state_d    = (imem.imem_rdata[15:11] == 5'b00000) ? ST_HALTED : ST_REQ;
          end
        end else if (!stallCtrl) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          halt_d  = 1'b0;
        end
      end
      ST_HOLD: begin
        if (!stallCtrl) begin
          instr_d    = skid_instr_q;
          pc_ifid_d  = skid_pc_q;
          pc2_ifid_d = skid_pc_q + 16'd2;
          halt_d     = (skid_instr_q[15:11] == 5'b00000);
          valid_d    = 1'b1;
          pc_d       = skid_pc_q + 16'd2;
          req_addr_d = skid_pc_q + 16'd2;
          state_d    = (skid_instr_q[15:11] == 5'b00000) ? ST_HALTED : ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem.imem_done) begin
          req_addr_d = pc_q;
          state_d    = ST_REQ;
        end
        if (!stallCtrl) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          halt_d  = 1'b0;
        end
      end
      default: begin
        if (!stallCtrl) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          halt_d  = 1'b0;
        end
      end
    endcase

    // Redirect wins over everything except reset, including a pending stall
    if (redirect) begin
      pc_d         = target;
      instr_d      = NOP_INSTR;
      valid_d      = 1'b0;
      halt_d       = 1'b0;
      pc_ifid_d    = pc_ifid_q;
      pc2_ifid_d   = pc2_ifid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      err_d        = err_q | target[0];
      if (in_flight && !imem.imem_done) begin
        state_d    = ST_DROP;
        req_addr_d = req_addr_q;
      end else begin
        state_d    = ST_REQ;
        req_addr_d = target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 16'h0000;
      instr_q      <= NOP_INSTR;
      pc_ifid_q    <= 16'h0000;
      pc2_ifid_q   <= 16'h0000;
      halt_q       <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_ifid_q    <= pc_ifid_d;
      pc2_ifid_q   <= pc2_ifid_d;
      halt_q       <= halt_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign instr_IFID = instr_q;
  assign PC_IFID    = pc_ifid_q;
  assign PC2_IFID   = pc2_ifid_q;
  assign halt_IFID  = halt_q;
  assign valid_IFID = valid_q;
  assign err        = err_q;

endmodule
